shift_rows_unit: RTL and testbench
==================================

Name: shift_rows_unit

Overview:
Registered AES ShiftRows / InvShiftRows byte-permutation stage for the AES datapath.
- Takes one 128-bit AES state per cycle and applies the forward (encrypt) or inverse (decrypt) row rotation, selected per transfer by `inv`.
- Presents the result one clock later with a valid flag.
- Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the round pipeline.

Parameters:
- None. Data width is fixed at 128 bits (16 bytes, 4x4 state).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  data_in and inv are valid this cycle
- inv  input  1  0 = ShiftRows (forward), 1 = InvShiftRows (inverse)
- data_in  input  128  input AES state
- out_valid  output  1  data_out holds a freshly computed result
- data_out  output  128  permuted AES state (registered)

Behaviour:
- Reset: one clock, synchronous, active-high, as already decided.
  - On a rising edge with rst=1: out_valid <= 0, data_out <= 128'h0.
  - rst takes priority over in_valid.
- Byte indexing:
  - Byte k (k = 0..15) occupies data[127-8k : 120-8k], so byte 0 is the MSB byte.
  - State element s[r][c] = byte k with k = 4c + r (column-major; r = row, c = column, 0..3).
- Forward mode (inv=0): out[r][c] = in[r][(c + r) mod 4]. Row r rotates left by r positions.
- Inverse mode (inv=1): out[r][c] = in[r][(c - r) mod 4]. Row r rotates right by r positions.
- Row 0 is never moved in either mode.
- Pure byte permutation: no arithmetic, no bit changes within a byte.
- Latency is exactly 1 cycle. On a rising edge with rst=0 and in_valid=1:
  - data_out <= permute(data_in, inv)
  - out_valid <= 1
- On a rising edge with rst=0 and in_valid=0:
  - out_valid <= 0
  - data_out holds its previous value.
- Throughput is one state per cycle; back-to-back in_valid is allowed with no bubbles. There is no backpressure input.
- inv is sampled together with data_in. Each transfer may use a different mode, and consecutive transfers may alternate modes.
- Round-trip identities:
  - InvShiftRows(ShiftRows(x)) = x for all x.
  - ShiftRows(InvShiftRows(x)) = x for all x.
- Reset mid-stream: a transfer presented on the same edge as rst=1 is discarded. The output is valid again one cycle after the first accepted in_valid following reset release.
- No combinational path from any input to any output.

Test Plan:
1. Reset:
   - Drive rst=1 for 2 cycles with in_valid=1 and arbitrary data.
   - Required: out_valid=0 and data_out=0 after each edge.
2. Forward, FIPS-197 pattern:
   - Apply inv=0, data_in=000102030405060708090A0B0C0D0E0F.
   - Required next cycle: out_valid=1, data_out=00050A0F04090E03080D02070C01060B.
3. Forward, row-tag pattern:
   - Apply inv=0, data_in=A5A4A3A2B5B4B3B2C5C4C3C2D5D4D3D2.
   - Required: data_out=A5B4C3D2B5C4D3A2C5D4A3B2D5A4B3C2.
4. Inverse, including back-to-back:
   - Apply inv=1, data_in=A5B4C3D2B5C4D3A2C5D4A3B2D5A4B3C2.
   - Required: data_out=A5A4A3A2B5B4B3B2C5C4C3C2D5D4D3D2.
   - Next cycle, apply inv=1, data_in=000102030405060708090A0B0C0D0E0F.
   - Required: data_out=000D0A0704010E0B0805020F0C090603.
5. Alternating modes and hold:
   - Stream forward then inverse of the same random word on consecutive cycles, then deassert in_valid.
   - Required: second result equals InvShiftRows of the word.
   - Required after deassert: out_valid=0 and data_out holds the last value.
   - Repeat for 1000 random words, checking both round-trip identities.
6. Reset mid-stream:
   - Assert rst on a cycle with in_valid=1.
   - Required: that transfer is dropped, out_valid=0 and data_out=0.
   - Required: the next accepted transfer appears normally one cycle later.

Source files
------------

// File: rtl/shift_rows_unit.sv
// AES ShiftRows / InvShiftRows stage with a one-cycle registered output.
// The state is 16 bytes. Byte 0 sits in the MSBs. Byte k holds element
// s[r][c], where k = 4c + r (column-major order). The forward mode rotates
// row r left by r positions. The inverse mode rotates row r right by r
// positions. Row 0 never moves.
module shift_rows_unit (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         inv,
    input  logic [127:0] data_in,
    output logic         out_valid,
    output logic [127:0] data_out
);

    logic         out_valid_d, out_valid_q;
    logic [127:0] data_out_d,  data_out_q;
    logic [127:0] perm;

    // Byte permutation: output element [r][c] takes input element [r][c+r]
    // in forward mode, or [r][c-r] in inverse mode. Columns wrap modulo 4.
    always_comb begin
        perm = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic [1:0] src_c;
                int         dst_k;
                int         src_k;
                src_c = inv ? 2'(c - r) : 2'(c + r);
                dst_k = 4 * c + r;
                src_k = 4 * int'(src_c) + r;
                perm[127 - 8*dst_k -: 8] = data_in[127 - 8*src_k -: 8];
            end
        end
    end

    // Next-state logic. A new result loads only on an accepted transfer.
    // When no transfer arrives, data_out keeps its last value.
    always_comb begin
        out_valid_d = in_valid;
        data_out_d  = data_out_q;
        if (in_valid) begin
            data_out_d = perm;
        end
    end

    // Output registers. Reset overrides a transfer arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_shift_rows_unit.sv
// Self-checking bench for shift_rows_unit: fixed vectors, random
// alternating-mode streams and reset corner cases, using a scoreboard queue.
module tb_shift_rows_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         inv;
    logic [127:0] data_in;
    logic         out_valid;
    logic [127:0] data_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];
    logic [127:0] last_exp = '0;

    shift_rows_unit dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .inv      (inv),
        .data_in  (data_in),
        .out_valid(out_valid),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Reference model. It slices each row into a 32-bit word and rotates
    // that word as a whole.
    function automatic logic [127:0] model(input logic [127:0] x, input logic i);
        logic [127:0] y;
        logic [31:0]  row, rot;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) row[31 - 8*c -: 8] = x[127 - 8*(4*c + r) -: 8];
            if (r == 0)   rot = row;
            else if (!i)  rot = (row << (8*r)) | (row >> (32 - 8*r));
            else          rot = (row >> (8*r)) | (row << (32 - 8*r));
            for (int c = 0; c < 4; c++) y[127 - 8*(4*c + r) -: 8] = rot[31 - 8*c -: 8];
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, then check the outputs 1 time unit after the edge.
    // Pass r, v, i, d and the expected permutation e for an accepted transfer.
    task automatic cycle(input logic r, input logic v, input logic i,
                         input logic [127:0] d, input logic [127:0] e);
        logic [127:0] ex;
        rst = r; in_valid = v; inv = i; data_in = d;
        if (v && !r) exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk("out_valid", 128'(out_valid), 128'(v && !r));
        if (v && !r) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 128'(1), 128'(0));
            end else begin
                ex = exp_q.pop_front();
                chk("data_out", data_out, ex);
                last_exp = ex;
            end
        end else if (r) begin
            chk("reset_data", data_out, '0);
            last_exp = '0;
        end else begin
            chk("hold_data", data_out, last_exp);
        end
    endtask

    typedef struct {
        logic         inv;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [127:0] x, y;

        vecs[0] = '{1'b0, 128'h000102030405060708090A0B0C0D0E0F, 128'h00050A0F04090E03080D02070C01060B};
        vecs[1] = '{1'b0, 128'hA5A4A3A2B5B4B3B2C5C4C3C2D5D4D3D2, 128'hA5B4C3D2B5C4D3A2C5D4A3B2D5A4B3C2};
        vecs[2] = '{1'b1, 128'hA5B4C3D2B5C4D3A2C5D4A3B2D5A4B3C2, 128'hA5A4A3A2B5B4B3B2C5C4C3C2D5D4D3D2};
        vecs[3] = '{1'b1, 128'h000102030405060708090A0B0C0D0E0F, 128'h000D0A0704010E0B0805020F0C090603};

        rst = 1'b0; in_valid = 1'b0; inv = 1'b0; data_in = '0;

        // Reset is held for two cycles while in_valid stays high.
        cycle(1'b1, 1'b1, 1'b0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, '0);
        cycle(1'b1, 1'b1, 1'b1, 128'h11111111_22222222_33333333_44444444, '0);

        // Table vectors run back to back, then one idle cycle checks the hold.
        foreach (vecs[n]) cycle(1'b0, 1'b1, vecs[n].inv, vecs[n].din, vecs[n].exp);
        cycle(1'b0, 1'b0, 1'b0, 128'h0, '0);

        // Random words stream forward then inverse, then go idle.
        // The DUT's forward result is fed back through inverse mode, and the
        // DUT's inverse result is fed back through forward mode.
        for (int n = 0; n < 1000; n++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            cycle(1'b0, 1'b1, 1'b0, x, model(x, 1'b0));
            y = data_out;
            cycle(1'b0, 1'b1, 1'b1, x, model(x, 1'b1));
            cycle(1'b0, 1'b0, 1'b0, 128'h0, '0);
            cycle(1'b0, 1'b1, 1'b1, y, model(y, 1'b1));
            chk("roundtrip_inv_fwd", data_out, x);
            y = data_out;
            cycle(1'b0, 1'b1, 1'b1, x, model(x, 1'b1));
            y = data_out;
            cycle(1'b0, 1'b1, 1'b0, y, model(y, 1'b0));
            chk("roundtrip_fwd_inv", data_out, x);
        end

        // Reset arrives mid-stream: the transfer on the reset edge is dropped,
        // and the next accepted transfer appears one cycle later.
        cycle(1'b0, 1'b1, 1'b0, vecs[0].din, vecs[0].exp);
        cycle(1'b1, 1'b1, 1'b1, vecs[3].din, '0);
        cycle(1'b0, 1'b0, 1'b0, 128'h0, '0);
        cycle(1'b0, 1'b1, 1'b1, vecs[2].din, vecs[2].exp);
        cycle(1'b0, 1'b0, 1'b0, 128'h0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
